// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants and helpers for the up/down modulo-M counter
package contador_pkg;

  localparam logic DIR_SOBE  = 1'b0;
  localparam logic DIR_DESCE = 1'b1;

  // Width needed to hold 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prescaler_m.sv
// rtl/prescaler_m.sv - modulo-P divider of the count-enable stream, one passo every P conta-high cycles
module prescaler_m
  import contador_pkg::*;
#(
  parameter int P = 4
) (
  input  logic clock,
  input  logic zera_as_n,
  input  logic zera_s,
  input  logic conta,
  output logic passo
);

  localparam int            W       = clog2(P);
  localparam logic [W-1:0] PRE_MAX = W'(P - 1);
  localparam logic [W-1:0] PRE_UM  = W'(1);

  logic [W-1:0] pre;

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      pre <= '0;
    end else if (zera_s) begin
      pre <= '0;
    end else if (conta) begin
      pre <= (pre == PRE_MAX) ? '0 : pre + PRE_UM;
    end
  end

  assign passo = conta && (pre == PRE_MAX);

endmodule

// File: rtl/contador_ud_m.sv
// rtl/contador_ud_m.sv - up/down modulo-M counter with load, wrap pulse and cascade terminal count
// Optional prescaler on the count enable when CONTADOR_UD_PRESC_EN is defined.
module contador_ud_m
  import contador_pkg::*;
#(
  parameter int M = 3001,
  parameter int N = 12,
  parameter int P = 4
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic         conta,
  input  logic         desce,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         zero,
  output logic         tc,
  output logic         vira,
  output logic         erro_carga
);

  localparam logic [N-1:0] Q_MAX  = N'(M - 1);
  localparam logic [N-1:0] Q_MEIO = N'(M / 2 - 1);
  localparam logic [N-1:0] Q_UM   = N'(1);

  if (M < 2 || (2 ** N) < M || P < 2) begin : g_param_invalido
    $error("contador_ud_m: invalid M/N/P combination");
  end

  logic passo;

`ifdef CONTADOR_UD_PRESC_EN
  // A load restarts the prescaler phase just like a clear.
  prescaler_m #(.P(P)) u_prescaler (
    .clock     (clock),
    .zera_as_n (zera_as_n),
    .zera_s    (zera_s | carrega),
    .conta     (conta),
    .passo     (passo)
  );
`else
  assign passo = conta;
`endif

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      Q          <= '0;
      vira       <= 1'b0;
      erro_carga <= 1'b0;
    end else if (zera_s) begin
      Q          <= '0;
      vira       <= 1'b0;
      erro_carga <= 1'b0;
    end else if (carrega) begin
      vira <= 1'b0;
      if (D > Q_MAX) begin
        Q          <= Q_MAX;
        erro_carga <= 1'b1;
      end else begin
        Q          <= D;
        erro_carga <= 1'b0;
      end
    end else begin
      erro_carga <= 1'b0;
      if (passo) begin
        if (desce == DIR_DESCE) begin
          Q    <= (Q == '0) ? Q_MAX : Q - Q_UM;
          vira <= (Q == '0);
        end else begin
          Q    <= (Q == Q_MAX) ? '0 : Q + Q_UM;
          vira <= (Q == Q_MAX);
        end
      end else begin
        vira <= 1'b0;
      end
    end
  end

  assign fim  = (Q == Q_MAX);
  assign meio = (Q == Q_MEIO);
  assign zero = (Q == '0);
  assign tc   = passo && ((desce == DIR_DESCE) ? zero : fim);

endmodule

// File: tb/tb_contador_ud_m.sv
// tb/tb_contador_ud_m.sv - directed self-checking bench for contador_ud_m with M = 10, N = 4
module tb_contador_ud_m;

  localparam int M = 10;
  localparam int N = 4;
  localparam int P = 4;

  logic         clock;
  logic         zera_as_n;
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] D;
  logic         conta;
  logic         desce;
  logic [N-1:0] Q;
  logic         fim, meio, zero, tc, vira, erro_carga;

  logic         c_conta;
  logic [N-1:0] c_lo_q, c_hi_q;
  logic         c_lo_tc, c_hi_tc;
  logic         c_lo_fim, c_lo_meio, c_lo_zero, c_lo_vira, c_lo_erro;
  logic         c_hi_fim, c_hi_meio, c_hi_zero, c_hi_vira, c_hi_erro;

  int n_checks = 0;
  int n_errors = 0;

  contador_ud_m #(.M(M), .N(N), .P(P)) dut (
    .clock      (clock),
    .zera_as_n  (zera_as_n),
    .zera_s     (zera_s),
    .carrega    (carrega),
    .D          (D),
    .conta      (conta),
    .desce      (desce),
    .Q          (Q),
    .fim        (fim),
    .meio       (meio),
    .zero       (zero),
    .tc         (tc),
    .vira       (vira),
    .erro_carga (erro_carga)
  );

  contador_ud_m #(.M(M), .N(N), .P(P)) dut_lo (
    .clock      (clock),
    .zera_as_n  (zera_as_n),
    .zera_s     (1'b0),
    .carrega    (1'b0),
    .D          (4'd0),
    .conta      (c_conta),
    .desce      (1'b0),
    .Q          (c_lo_q),
    .fim        (c_lo_fim),
    .meio       (c_lo_meio),
    .zero       (c_lo_zero),
    .tc         (c_lo_tc),
    .vira       (c_lo_vira),
    .erro_carga (c_lo_erro)
  );

  contador_ud_m #(.M(M), .N(N), .P(P)) dut_hi (
    .clock      (clock),
    .zera_as_n  (zera_as_n),
    .zera_s     (1'b0),
    .carrega    (1'b0),
    .D          (4'd0),
    .conta      (c_lo_tc),
    .desce      (1'b0),
    .Q          (c_hi_q),
    .fim        (c_hi_fim),
    .meio       (c_hi_meio),
    .zero       (c_hi_zero),
    .tc         (c_hi_tc),
    .vira       (c_hi_vira),
    .erro_carga (c_hi_erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge_tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_q;

    zera_as_n = 1'b0;
    zera_s    = 1'b0;
    carrega   = 1'b0;
    D         = '0;
    conta     = 1'b1;
    desce     = 1'b0;
    c_conta   = 1'b0;

    // Reset held with conta high: nothing moves.
    for (int i = 0; i < 3; i++) begin
      edge_tick();
      check("rst_q", Q, 0);
      check("rst_zero", zero, 1);
      check("rst_vira", vira, 0);
      check("rst_erro", erro_carga, 0);
    end
    check("rst_fim", fim, 0);
    check("rst_tc", tc, 0);
    conta     = 1'b0;
    zera_as_n = 1'b1;
    edge_tick();
    check("rel_q", Q, 0);

`ifdef CONTADOR_UD_PRESC_EN
    conta = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      edge_tick();
      check("pre_q", Q, i / 4);
    end
    edge_tick();
    edge_tick();
    check("pre_mid_q", Q, 2);
    carrega = 1'b1;
    D       = 4'd5;
    edge_tick();
    carrega = 1'b0;
    check("pre_load_q", Q, 5);
    for (int i = 1; i <= 4; i++) begin
      edge_tick();
      check("pre_after_load_q", Q, (i == 4) ? 6 : 5);
    end
    conta = 1'b0;
`else
    // Up wrap from 0 across ten steps.
    conta = 1'b1;
    desce = 1'b0;
    check("up_tc_pre", tc, 0);
    for (int i = 1; i <= 10; i++) begin
      edge_tick();
      exp_q = i % 10;
      check("up_q", Q, exp_q);
      check("up_fim", fim, exp_q == 9);
      check("up_meio", meio, exp_q == 4);
      check("up_tc", tc, exp_q == 9);
      check("up_vira", vira, i == 10);
    end
    conta = 1'b0;
    edge_tick();
    check("up_vira_drop", vira, 0);
    check("up_hold_q", Q, 0);

    // Down wrap after loading 1.
    carrega = 1'b1;
    D       = 4'd1;
    edge_tick();
    carrega = 1'b0;
    check("dn_load_q", Q, 1);
    check("dn_load_erro", erro_carga, 0);
    conta = 1'b1;
    desce = 1'b1;
    check("dn_tc_q1", tc, 0);
    edge_tick();
    check("dn_q0", Q, 0);
    check("dn_tc_q0", tc, 1);
    check("dn_vira0", vira, 0);
    edge_tick();
    check("dn_q9", Q, 9);
    check("dn_vira9", vira, 1);
    check("dn_tc_q9", tc, 0);
    edge_tick();
    check("dn_q8", Q, 8);
    check("dn_vira8", vira, 0);
    conta = 1'b0;

    // Out-of-range load clamps and flags once.
    carrega = 1'b1;
    D       = 4'd12;
    edge_tick();
    carrega = 1'b0;
    check("clamp_q", Q, 9);
    check("clamp_erro", erro_carga, 1);
    edge_tick();
    check("clamp_erro_drop", erro_carga, 0);
    check("clamp_hold_q", Q, 9);
    carrega = 1'b1;
    D       = 4'd9;
    edge_tick();
    check("load9_erro", erro_carga, 0);

    // Clear beats load beats step.
    zera_s = 1'b1;
    D      = 4'd5;
    conta  = 1'b1;
    edge_tick();
    zera_s = 1'b0;
    check("prio_clr_q", Q, 0);
    D = 4'd7;
    edge_tick();
    carrega = 1'b0;
    check("prio_load_q", Q, 7);

    // Direction change mid-count.
    desce = 1'b0;
    edge_tick();
    check("dir_up_q", Q, 8);
    desce = 1'b1;
    edge_tick();
    check("dir_dn_q", Q, 7);

    // Asynchronous reset kills a pending wrap pulse.
    desce   = 1'b0;
    carrega = 1'b1;
    D       = 4'd8;
    edge_tick();
    carrega = 1'b0;
    edge_tick();
    check("ar_q9", Q, 9);
    edge_tick();
    check("ar_vira_set", vira, 1);
    zera_as_n = 1'b0;
    #1;
    check("ar_vira_clr", vira, 0);
    check("ar_q", Q, 0);
    conta     = 1'b0;
    zera_as_n = 1'b1;
    carrega   = 1'b1;
    D         = 4'd15;
    edge_tick();
    carrega = 1'b0;
    check("ar_erro_set", erro_carga, 1);
    zera_as_n = 1'b0;
    #1;
    check("ar_erro_clr", erro_carga, 0);
    zera_as_n = 1'b1;
    edge_tick();

    // Two-digit cascade, 25 steps.
    c_conta = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      edge_tick();
      if (i == 10) begin
        check("cas10_lo", c_lo_q, 0);
        check("cas10_hi", c_hi_q, 1);
      end
    end
    c_conta = 1'b0;
    check("cas_lo", c_lo_q, 5);
    check("cas_hi", c_hi_q, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
